// File: rtl/bbp_update_arbiter_if.sv
// ---------------------------------------------------------------------------
// bbp_update_arbiter_if
//   Bundle between the branch-resolve requesters, the update arbiter and the
//   bimodal predictor write port.
//
//   Request side (two ports; port 0 = older branch slot, port 1 = younger):
//     reqN_valid / reqN_pc[31:0] / reqN_taken  -> arbiter
//     reqN_ready                               <- arbiter
//   Predictor side:
//     bbp_write / bbp_write_pc[31:0] / bbp_write_data  <- arbiter (registered)
//     bbp_busy                                         <- arbiter
//
//   modport slave  : the arbiter
//   modport master : the environment (requesters + predictor/fetch)
// ---------------------------------------------------------------------------
interface bbp_update_arbiter_if;
  logic        req0_valid;
  logic [31:0] req0_pc;
  logic        req0_taken;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_pc;
  logic        req1_taken;
  logic        req1_ready;
  logic        bbp_write;
  logic [31:0] bbp_write_pc;
  logic        bbp_write_data;
  logic        bbp_busy;

  modport slave (
    input  req0_valid, req0_pc, req0_taken,
    input  req1_valid, req1_pc, req1_taken,
    output req0_ready, req1_ready,
    output bbp_write, bbp_write_pc, bbp_write_data, bbp_busy
  );

  modport master (
    output req0_valid, req0_pc, req0_taken,
    output req1_valid, req1_pc, req1_taken,
    input  req0_ready, req1_ready,
    input  bbp_write, bbp_write_pc, bbp_write_data, bbp_busy
  );
endinterface

// File: rtl/bbp_update_arbiter.sv
// ---------------------------------------------------------------------------
// bbp_update_arbiter
//   Collects branch-resolution updates from two requesters, buffers them in a
//   DEPTH-entry FIFO and issues at most one registered write per cycle to the
//   bimodal predictor table.
//
// Ports:
//   CLK            clock, rising edge
//   RESET          asynchronous, active-low reset
//   flush          synchronous; drops every pending (not yet issued) update
//   upd            bbp_update_arbiter_if.slave: request handshakes, predictor
//                  write strobe/PC/data and busy indication
//   count          current FIFO occupancy (PTR_W+1 bits)
//   stat_issued    issued-update counter
//   stat_stall     cycles with at least one valid-but-not-ready request
//
// Parameters:
//   DEPTH  FIFO entries, power of two, >= 2
//   PTR_W  log2(DEPTH)
//
// Build option:
//   BBP_UPD_STATS_EN  when defined, stat_issued/stat_stall are live wrapping
//                     32-bit counters (cleared by reset only); otherwise both
//                     outputs are tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module bbp_update_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               flush,
  bbp_update_arbiter_if.slave upd,
  output logic [PTR_W:0]     count,
  output logic [31:0]        stat_issued,
  output logic [31:0]        stat_stall
);

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } entry_t;

  localparam logic [PTR_W:0] DEPTH_W = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_W   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] TWO_W   = (PTR_W+1)'(2);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             bbp_write_q, bbp_write_d;
  logic [31:0]      bbp_write_pc_q, bbp_write_pc_d;
  logic             bbp_write_data_q, bbp_write_data_d;

  logic [PTR_W:0]   free;
  logic             ready0, ready1;
  logic             enq0, enq1, deq;

  // Space is judged on the registered occupancy only, so a pop in the same
  // cycle never frees a slot for a push.
  always_comb begin
    free   = DEPTH_W - count_q;
    ready0 = !flush && ((free >= TWO_W) || ((free == ONE_W) && !rr_ptr_q));
    ready1 = !flush && ((free >= TWO_W) || ((free == ONE_W) &&  rr_ptr_q));
    enq0   = upd.req0_valid && ready0;
    enq1   = upd.req1_valid && ready1;
    deq    = !flush && (count_q != '0);
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred; blocking '=' is correct inside
  // always_comb because later lines depend on earlier ones.
  always_comb begin
    mem_d            = mem_q;
    wr_ptr_d         = wr_ptr_q + PTR_W'(enq0) + PTR_W'(enq1);
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    bbp_write_d      = deq;
    bbp_write_pc_d   = bbp_write_pc_q;
    bbp_write_data_d = bbp_write_data_q;

    // Port 0 takes the lower slot when both push in the same cycle.
    if (enq0) mem_d[wr_ptr_q] = '{pc: upd.req0_pc, taken: upd.req0_taken};
    if (enq1) mem_d[wr_ptr_q + PTR_W'(enq0)] = '{pc: upd.req1_pc, taken: upd.req1_taken};

    if (flush) begin
      // Readies are low during flush, so nothing was pushed; just equalise.
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      count_d  = count_q + (PTR_W+1)'(enq0) + (PTR_W+1)'(enq1) - (PTR_W+1)'(deq);
      rd_ptr_d = rd_ptr_q + PTR_W'(deq);
    end

    if (deq) begin
      bbp_write_pc_d   = mem_q[rd_ptr_q].pc;
      bbp_write_data_d = mem_q[rd_ptr_q].taken;
    end

    // Priority only rotates when the last free slot went to the favoured port.
    rr_ptr_d = rr_ptr_q ^ ((free == ONE_W) && (rr_ptr_q ? enq1 : enq0));
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      rr_ptr_q         <= 1'b0;
      bbp_write_q      <= 1'b0;
      bbp_write_pc_q   <= '0;
      bbp_write_data_q <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      rr_ptr_q         <= rr_ptr_d;
      bbp_write_q      <= bbp_write_d;
      bbp_write_pc_q   <= bbp_write_pc_d;
      bbp_write_data_q <= bbp_write_data_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, and leaving it unreset keeps it a plain register file.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign upd.req0_ready     = ready0;
  assign upd.req1_ready     = ready1;
  assign upd.bbp_write      = bbp_write_q;
  assign upd.bbp_write_pc   = bbp_write_pc_q;
  assign upd.bbp_write_data = bbp_write_data_q;
  assign upd.bbp_busy       = (count_q != '0) || bbp_write_q;
  assign count              = count_q;

`ifdef BBP_UPD_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_stall_q,  stat_stall_d;

  // One stall tick per edge even when both ports are held off.
  always_comb begin
    stat_issued_d = stat_issued_q + 32'(deq);
    stat_stall_d  = stat_stall_q +
                    32'((upd.req0_valid && !ready0) || (upd.req1_valid && !ready1));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`else
  assign stat_issued = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_bbp_update_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bbp_update_arbiter
//   Self-checking bench for bbp_update_arbiter (DEPTH=4). A queue-based model
//   tracks pending updates, priority and the registered write outputs; every
//   cycle the DUT's readies and registered outputs are compared to it, and a
//   set of directed sequences pins literal expectations.
// ---------------------------------------------------------------------------
module tb_bbp_update_arbiter;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
`ifdef BBP_UPD_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic             CLK   = 1'b0;
  logic             RESET = 1'b0;
  logic             flush = 1'b0;
  logic [PTR_W:0]   count;
  logic [31:0]      stat_issued;
  logic [31:0]      stat_stall;

  bbp_update_arbiter_if u_if ();

  bbp_update_arbiter #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .flush       (flush),
    .upd         (u_if),
    .count       (count),
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic        taken;
  } ent_t;

  ent_t        mq[$];
  bit          m_rr;
  bit          m_write;
  logic [31:0] m_pc;
  bit          m_data;
  int unsigned m_issued, m_stall;
  int          acc_total, iss_total, drop_total, max_cnt;
  int          n_cmp, n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready(input int port);
    int free;
    free = DEPTH - mq.size();
    if (flush) return 1'b0;
    if (free >= 2) return 1'b1;
    if (free == 1) return (port == int'(m_rr));
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rr = 0; m_write = 0; m_pc = '0; m_data = 0;
    m_issued = 0; m_stall = 0;
  endtask

  task automatic compare_outputs();
    check("count",          32'(count),               32'(mq.size()));
    check("bbp_write",      32'(u_if.bbp_write),      32'(m_write));
    check("bbp_write_pc",   u_if.bbp_write_pc,        m_pc);
    check("bbp_write_data", 32'(u_if.bbp_write_data), 32'(m_data));
    check("bbp_busy",       32'(u_if.bbp_busy),       32'((mq.size() != 0) || m_write));
    check("stat_issued",    stat_issued,              STATS_EN ? m_issued : 32'd0);
    check("stat_stall",     stat_stall,               STATS_EN ? m_stall  : 32'd0);
    if (int'(count) > max_cnt) max_cnt = int'(count);
  endtask

  // Drive inputs on the falling edge, then check combinational readies.
  task automatic drive(input bit v0, input logic [31:0] p0, input bit t0,
                       input bit v1, input logic [31:0] p1, input bit t1,
                       input bit fl);
    @(negedge CLK);
    u_if.req0_valid = v0; u_if.req0_pc = p0; u_if.req0_taken = t0;
    u_if.req1_valid = v1; u_if.req1_pc = p1; u_if.req1_taken = t1;
    flush = fl;
    #1;
    check("req0_ready", 32'(u_if.req0_ready), 32'(m_ready(0)));
    check("req1_ready", 32'(u_if.req1_ready), 32'(m_ready(1)));
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, '0, 0, 0);
  endtask

  // Advance the model across the next rising edge, then compare outputs.
  task automatic edge_step();
    bit   r0, r1, e0, e1;
    int   free;
    ent_t e;
    r0   = m_ready(0);
    r1   = m_ready(1);
    e0   = u_if.req0_valid && r0;
    e1   = u_if.req1_valid && r1;
    free = DEPTH - mq.size();
    if ((u_if.req0_valid && !r0) || (u_if.req1_valid && !r1)) m_stall++;
    if (flush) begin
      drop_total += mq.size();
      mq.delete();
      m_write = 0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_write = 1; m_pc = e.pc; m_data = e.taken;
      m_issued++; iss_total++;
    end else begin
      m_write = 0;
    end
    if (e0) mq.push_back('{pc: u_if.req0_pc, taken: u_if.req0_taken});
    if (e1) mq.push_back('{pc: u_if.req1_pc, taken: u_if.req1_taken});
    acc_total += int'(e0) + int'(e1);
    if (free == 1 && (m_rr ? e1 : e0)) m_rr = !m_rr;
    @(posedge CLK);
    #1;
    compare_outputs();
  endtask

  task automatic step(input bit v0, input logic [31:0] p0, input bit t0,
                      input bit v1, input logic [31:0] p1, input bit t1,
                      input bit fl);
    drive(v0, p0, t0, v1, p1, t1, fl);
    edge_step();
  endtask

  task automatic idle_step();
    idle();
    edge_step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},       32'(count),               32'd0);
    check({tag, "_write"},       32'(u_if.bbp_write),      32'd0);
    check({tag, "_write_pc"},    u_if.bbp_write_pc,        32'd0);
    check({tag, "_write_data"},  32'(u_if.bbp_write_data), 32'd0);
    check({tag, "_busy"},        32'(u_if.bbp_busy),       32'd0);
    check({tag, "_stat_issued"}, stat_issued,              32'd0);
    check({tag, "_stat_stall"},  stat_stall,               32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    u_if.req0_valid = 0; u_if.req0_pc = '0; u_if.req0_taken = 0;
    u_if.req1_valid = 0; u_if.req1_pc = '0; u_if.req1_taken = 0;
    flush = 0;
    RESET = 0;
    #1;
    model_reset();
    check_reset_state("reset");
    repeat (2) @(negedge CLK);
    RESET = 1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    acc_total = 0; iss_total = 0; drop_total = 0; max_cnt = 0;
    model_reset();

    // ---- 1: single request, two-edge latency ----
    do_reset();
    step(1, 32'h0000_031C, 1, 0, '0, 0, 0);
    check("t1_count_after_accept", 32'(count), 32'd1);
    idle_step();
    check("t1_write",   32'(u_if.bbp_write),      32'd1);
    check("t1_pc",      u_if.bbp_write_pc,        32'h0000_031C);
    check("t1_data",    32'(u_if.bbp_write_data), 32'd1);
    check("t1_count",   32'(count),               32'd0);
    idle_step();
    check("t1_busy_low", 32'(u_if.bbp_busy), 32'd0);
    check("t1_pc_held",  u_if.bbp_write_pc,  32'h0000_031C);

    // ---- 2: both ports at once, port 0 first ----
    step(1, 32'h100, 1, 1, 32'h104, 0, 0);
    idle_step();
    check("t2_w0",    32'(u_if.bbp_write),      32'd1);
    check("t2_pc0",   u_if.bbp_write_pc,        32'h100);
    check("t2_data0", 32'(u_if.bbp_write_data), 32'd1);
    idle_step();
    check("t2_w1",    32'(u_if.bbp_write),      32'd1);
    check("t2_pc1",   u_if.bbp_write_pc,        32'h104);
    check("t2_data1", 32'(u_if.bbp_write_data), 32'd0);
    idle_step();
    check("t2_w_end", 32'(u_if.bbp_write), 32'd0);

    // ---- 4: flush with three entries queued ----
    step(1, 32'h10, 1, 1, 32'h14, 1, 0);
    step(1, 32'h18, 0, 1, 32'h1C, 1, 0);
    check("t4_count3", 32'(count), 32'd3);
    drive(1, 32'h20, 1, 1, 32'h24, 1, 1);
    check("t4_ready0_flush", 32'(u_if.req0_ready), 32'd0);
    check("t4_ready1_flush", 32'(u_if.req1_ready), 32'd0);
    edge_step();
    check("t4_count0",      32'(count),          32'd0);
    check("t4_write_after", 32'(u_if.bbp_write), 32'd0);
    idle_step();
    check("t4_no_write", 32'(u_if.bbp_write), 32'd0);
    step(1, 32'h200, 1, 0, '0, 0, 0);
    check("t4_not_yet", 32'(u_if.bbp_write), 32'd0);
    idle_step();
    check("t4_write_new", 32'(u_if.bbp_write), 32'd1);
    check("t4_pc_new",    u_if.bbp_write_pc,   32'h200);
    idle_step();

    // ---- 3: saturating traffic, then random traffic with flushes ----
    for (int i = 0; i < 120; i++)
      step(1, $urandom & 32'hFFFF_FFFC, 1'($urandom), 1, $urandom & 32'hFFFF_FFFC, 1'($urandom), 0);
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom),
           1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom),
           ($urandom_range(0, 15) == 0));
    repeat (6) idle_step();
    check("t3_drained",      32'(count),                   32'd0);
    check("t3_conservation", 32'(acc_total),               32'(iss_total + drop_total));
    check("t3_max_count_le", 32'(max_cnt <= DEPTH),        32'd1);

    // ---- 5: asynchronous reset mid-stream ----
    step(1, 32'h300, 1, 1, 32'h304, 1, 0);
    step(1, 32'h308, 1, 1, 32'h30C, 0, 0);
    check("t5_pre_write", 32'(u_if.bbp_write), 32'd1);
    @(negedge CLK);
    #2;
    RESET = 0;
    #1;
    check("t5_async_write", 32'(u_if.bbp_write),      32'd0);
    check("t5_async_pc",    u_if.bbp_write_pc,        32'd0);
    check("t5_async_data",  32'(u_if.bbp_write_data), 32'd0);
    check("t5_async_count", 32'(count),               32'd0);
    check("t5_async_busy",  32'(u_if.bbp_busy),       32'd0);
    model_reset();
    do_reset();
    step(1, 32'h400, 1, 1, 32'h404, 0, 0);
    step(1, 32'h408, 0, 1, 32'h40C, 1, 0);
    drive(1, 32'h410, 1, 1, 32'h414, 1, 0);
    check("t5_prio_ready0", 32'(u_if.req0_ready), 32'd1);
    check("t5_prio_ready1", 32'(u_if.req1_ready), 32'd0);
    edge_step();
    check("t5_first_pc", u_if.bbp_write_pc, 32'h404);
    repeat (6) idle_step();

    // ---- 6: statistics ----
    do_reset();
    step(1, 32'h500, 1, 1, 32'h504, 0, 0);
    step(1, 32'h508, 1, 1, 32'h50C, 1, 0);
    step(1, 32'h510, 0, 0, '0, 0, 0);
    step(0, '0, 0, 1, 32'h514, 1, 0);
    repeat (3) idle_step();
    repeat (3) step(1, 32'h600, 1, 0, '0, 0, 1);
    check("t6_stat_issued", stat_issued, STATS_EN ? 32'd6 : 32'd0);
    check("t6_stat_stall",  stat_stall,  STATS_EN ? 32'd3 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
